// File: rtl/clk_divider_multi_if.sv
// Bus between the divisor programmer and clk_divider_multi.
// With CLK_DIV_PHASE_SYNC_EN defined, a phase-sync strobe is added to the bus.
interface clk_divider_multi_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic                update;
    logic [SEL_W-1:0]    sel;
    logic [WIDTH-1:0]    div;
    logic [CHANNELS-1:0] div_clk;
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] pending;
`ifdef CLK_DIV_PHASE_SYNC_EN
    logic                sync;

    modport master (output update, sel, div, sync, input div_clk, tick, pending);
    modport slave  (input update, sel, div, sync, output div_clk, tick, pending);
`else
    modport master (output update, sel, div, input div_clk, tick, pending);
    modport slave  (input update, sel, div, output div_clk, tick, pending);
`endif
endinterface

// File: rtl/clk_divider_multi.sv
// Multi-channel glitch-free clock divider with staged divisor updates.
// Optional CLK_DIV_PHASE_SYNC_EN adds a sync strobe that re-phases all channels.
module clk_divider_lane #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             wr,
    input  logic             sync,
    input  logic [WIDTH-1:0] wdata,
    output logic             div_clk,
    output logic             tick,
    output logic             pending
);
    logic [WIDTH-1:0] d, s, cnt, d_nxt, cnt_nxt;
    logic             p, p_clr, primed, primed_nxt, run, run_nxt, clk_nxt;

    assign run     = d > WIDTH'(1);
    assign pending = p;

    always_comb begin
        d_nxt      = d;
        cnt_nxt    = cnt;
        primed_nxt = 1'b0;
        p_clr      = 1'b0;
        if (sync) begin
            if (p) begin
                d_nxt = s;
                p_clr = 1'b1;
            end
            cnt_nxt    = '0;
            primed_nxt = 1'b1;
        end else if (!run) begin
            cnt_nxt = '0;
            if (p) begin
                d_nxt      = s;
                p_clr      = 1'b1;
                primed_nxt = 1'b1;
            end
        end else if (primed) begin
            // load edge held output low; this edge delivers phase 0 (the rise)
            cnt_nxt = '0;
        end else if (cnt == d - WIDTH'(1)) begin
            cnt_nxt = '0;
            if (p) begin
                d_nxt = s;
                p_clr = 1'b1;
            end
        end else begin
            cnt_nxt = cnt + WIDTH'(1);
        end
        run_nxt = d_nxt > WIDTH'(1);
        clk_nxt = run_nxt && !primed_nxt && (cnt_nxt < (d_nxt >> 1));
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            d       <= '0;
            s       <= '0;
            cnt     <= '0;
            p       <= 1'b0;
            primed  <= 1'b0;
            div_clk <= 1'b0;
            tick    <= 1'b0;
        end else begin
            d       <= d_nxt;
            cnt     <= cnt_nxt;
            primed  <= primed_nxt && run_nxt;
            div_clk <= clk_nxt;
            tick    <= clk_nxt && !div_clk;
            // a write on the apply edge re-stages for the following period
            if (wr) begin
                s <= wdata;
                p <= 1'b1;
            end else if (p_clr) begin
                p <= 1'b0;
            end
        end
    end
endmodule

module clk_divider_multi #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input logic               clk,
    input logic               nRst,
    clk_divider_multi_if.slave bus
);
    logic sync_s;

`ifdef CLK_DIV_PHASE_SYNC_EN
    assign sync_s = bus.sync;
`else
    assign sync_s = 1'b0;
`endif

    // selects at or above CHANNELS match no lane and are dropped
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_lane
        clk_divider_lane #(.WIDTH(WIDTH)) u_lane (
            .clk     (clk),
            .nRst    (nRst),
            .wr      (bus.update && (bus.sel == SEL_W'(ch))),
            .sync    (sync_s),
            .wdata   (bus.div),
            .div_clk (bus.div_clk[ch]),
            .tick    (bus.tick[ch]),
            .pending (bus.pending[ch])
        );
    end
endmodule
